mem_stage_unit: RTL

//  Parametrised MEM-stage unit for the ARM pipeline: wraps a single-clock byte-addressed data RAM

---
 rtl/mem_stage_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_stage_unit.sv
// MEM-stage unit: byte-addressed data RAM behind a valid/ready handshake with
// programmable wait states, B/H/W/D sized accesses, fault checks and branch resolution.
module mem_stage_unit #(
  parameter int unsigned WORD        = 64,
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            uncondbranch,
  input  logic            branch,
  input  logic            branch_nz,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [1:0]      mem_size,
  input  logic            sign_ext,
  input  logic            zero,
  input  logic [WORD-1:0] address,
  input  logic [WORD-1:0] write_data,
  output logic            out_valid,
  output logic            pc_src,
  output logic [WORD-1:0] read_data,
  output logic            fault
);

  localparam int unsigned NBYTES = WORD / 8;
  localparam int unsigned OFF_W  = $clog2(NBYTES);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 4;
  localparam logic [WORD-1:0] MEM_BYTES = WORD'(DEPTH * NBYTES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              accept, commit;

  logic              r_ub, r_br, r_bnz, r_rd, r_wr, r_sext, r_zero;
  logic [1:0]        r_size;
  logic [WORD-1:0]   r_addr, r_wdata;

  logic [WORD-1:0]   mem [DEPTH];

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  int unsigned       nbytes;
  logic              flt, sbit, take;
  logic [WORD-1:0]   rd_word, shifted, mask, ld_data, wr_word;

  assign in_ready = (state != ACCESS);
  assign accept   = in_valid & in_ready;
  assign commit   = (state == ACCESS) && (cnt == '0);

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ACCESS;
      ACCESS:  if (commit) state_nx = DONE;
      DONE:    state_nx = accept ? ACCESS : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept)
        cnt <= CNT_W'(WAIT_STATES);
      else if (state == ACCESS && cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end

  // Request capture at acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      {r_ub, r_br, r_bnz, r_rd, r_wr, r_sext, r_zero} <= '0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (accept) begin
      r_ub    <= uncondbranch;
      r_br    <= branch;
      r_bnz   <= branch_nz;
      r_rd    <= MemRead;
      r_wr    <= MemWrite;
      r_sext  <= sign_ext;
      r_zero  <= zero;
      r_size  <= mem_size;
      r_addr  <= address;
      r_wdata <= write_data;
    end
  end

  // Fault checks, lane extraction/extension and store byte merge
  always_comb begin
    nbytes  = 32'(1) << r_size;
    off     = r_addr[OFF_W-1:0];
    idx     = r_addr[IDX_W+OFF_W-1:OFF_W];
    flt     = (r_rd | r_wr) &
              ((r_rd & r_wr) | (nbytes > NBYTES) |
               ((r_addr & WORD'(nbytes - 1)) != '0) | (r_addr >= MEM_BYTES));
    take    = r_ub | (r_br & r_zero) | (r_bnz & ~r_zero);
    rd_word = mem[idx];
    shifted = rd_word >> {off, 3'b000};
    mask    = '0;
    sbit    = 1'b0;
    for (int i = 0; i < int'(WORD); i++) begin
      mask[i] = (i < int'(nbytes * 8));
      if (i == int'(nbytes * 8) - 1) sbit = shifted[i];
    end
    ld_data = (shifted & mask) | ((r_sext && sbit) ? ~mask : '0);
    wr_word = rd_word;
    for (int b = 0; b < int'(NBYTES); b++) begin
      if (b >= int'(off) && b < int'(off) + int'(nbytes))
        wr_word[b*8 +: 8] = r_wdata[(b - int'(off))*8 +: 8];
    end
  end

  // Result registers update only on the DONE-entry edge
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      pc_src    <= 1'b0;
      fault     <= 1'b0;
      read_data <= '0;
    end else begin
      out_valid <= commit;
      if (commit) begin
        pc_src    <= take;
        fault     <= flt;
        read_data <= (r_rd && !flt) ? ld_data : '0;
      end
    end
  end

  // RAM write; reset on the commit edge suppresses it
  always_ff @(posedge clk) begin
    if (!reset && commit && r_wr && !flt)
      mem[idx] <= wr_word;
  end

endmodule
